nibble_deser: RTL and testbench
===============================

NIBBLE_DESER -- requirements
Module: nibble_deser

Interface
REQ-001 Parameter: CHECK_SEQ, default 1, enables the sequence checker (0 = seq_err tied low).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 En  input  1  receive enable; 0 = freeze all state except reset.
REQ-005 start  input  1  frame start, sampled with the first data bit.
REQ-006 sin  input  1  serial data input (shift-register serial output).
REQ-007 dir  input  1  bit order: 0 = MSB first (left shift), 1 = LSB first (right shift).
REQ-008 bcd  input  1  1 = BCD range check and BCD sequence modulus; 0 = binary.
REQ-009 up  input  1  expected count direction for the sequence checker: 1 = up, 0 = down.
REQ-010 Q  output  4  last fully received nibble.
REQ-011 valid  output  1  one-cycle pulse; Q is new.
REQ-012 range_err  output  1  pulses with valid when bcd=1 and Q > 9.
REQ-013 seq_err  output  1  pulses with valid when Q differs from the expected successor.

Function
REQ-014 FSM states SHALL be IDLE and SHIFT; a 2-bit bit counter SHALL index bits 0..3.
REQ-015 IDLE -> SHIFT SHALL occur on an edge with En=1 and start=1; sin on that edge SHALL be captured as bit 0.
REQ-016 In SHIFT, each edge with En=1 SHALL capture one bit; bits 1, 2 and 3 SHALL be captured on three subsequent enabled edges.
REQ-017 With dir=0, the first bit SHALL be Q[3] and the last Q[0]; with dir=1, the first bit SHALL be Q[0] and the last Q[3].
REQ-018 dir, bcd and up SHALL be latched at frame start; changes mid-frame SHALL have no effect on the current frame.
REQ-019 On the edge capturing bit 3: Q SHALL load the assembled nibble, valid SHALL assert for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency: with En held at 1, valid SHALL be high in the cycle after the 4th enabled edge counted from the start edge.
REQ-021 A start on the edge immediately after bit 3 SHALL begin a new frame, giving back-to-back frames with no gap cycle.
REQ-022 start asserted while in SHIFT SHALL be ignored and SHALL NOT restart the frame.
REQ-023 En=0 in SHIFT SHALL hold the bit counter and partial data; no bit is captured and there is no timeout.
REQ-024 Q SHALL hold its value between frames; valid, range_err and seq_err SHALL be low except during the valid cycle.
REQ-025 Expected successor, computed from the previous Q using that frame's latched modes:
- up=1, binary: prev+1, with 15 wrapping to 0.
- up=1, bcd: prev+1, with 9 wrapping to 0.
- up=0, binary: prev-1, with 0 wrapping to 15.
- up=0, bcd: prev-1, with 0 wrapping to 9.
REQ-026 When bcd=1 and prev > 9, the expected successor SHALL be 0 for up and 9 for down.
REQ-027 seq_err SHALL NOT assert on the first frame after reset (a has_prev flag is clear).
REQ-028 range_err and seq_err SHALL be able to assert together in the same valid cycle.

Reset
REQ-029 rstn=0 SHALL immediately force: FSM=IDLE, bit counter=0, Q=4'b0000, valid=0, range_err=0, seq_err=0, has_prev=0.
REQ-030 Reset mid-frame SHALL discard the partial nibble; the first start after rstn rises SHALL begin a clean frame.

Verification
REQ-031 dir=0, start with sin=1,0,1,1 on 4 edges -> valid one cycle, Q=4'b1011, range_err=0, seq_err=0 (first frame).
REQ-032 dir=1, sin=1,0,1,1 -> Q=4'b1101; then bcd=1, up=1 frame 4'b1110 -> range_err=1, seq_err=1 (expected 0).
REQ-033 Back-to-back binary up frames 14, 15, 0 -> three valid pulses 4 cycles apart, seq_err=0 throughout (wrap 15->0).
REQ-034 bcd=1, up=0 frames 0 then 9 -> seq_err=0; frames 5 then 3 -> seq_err=1 on the second.
REQ-035 En=0 for 3 cycles after bit 1, then resumed -> Q correct, valid delayed by exactly 3 cycles; a start pulse mid-frame is ignored.
REQ-036 rstn low after bit 2, released, new frame 4'b0110 -> Q=0110, seq_err=0 (has_prev cleared).

Source files
------------

// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer with selectable bit order, a BCD range check and an
// up/down sequence checker that compares each nibble against the previous one.
module nibble_deser #(
    parameter int CHECK_SEQ = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       En,
    input  logic       start,
    input  logic       sin,
    input  logic       dir,
    input  logic       bcd,
    input  logic       up,
    output logic [3:0] Q,
    output logic       valid,
    output logic       range_err,
    output logic       seq_err
);

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    logic       state;
    logic [1:0] cnt;
    logic [3:0] sh;
    logic       dir_l;
    logic       bcd_l;
    logic       up_l;
    logic       has_prev;

    logic [3:0] nxt_sh;
    logic [3:0] succ;
    logic       seq_hit;

    // Bit order is fixed by the mode latched at frame start, not the live input.
    assign nxt_sh = dir_l ? {sin, sh[3:1]} : {sh[2:0], sin};

    always_comb begin
        succ = 4'd0;
        if (bcd_l) begin
            if (Q > 4'd9) begin
                succ = up_l ? 4'd0 : 4'd9;
            end else if (up_l) begin
                succ = (Q == 4'd9) ? 4'd0 : Q + 4'd1;
            end else begin
                succ = (Q == 4'd0) ? 4'd9 : Q - 4'd1;
            end
        end else begin
            succ = up_l ? Q + 4'd1 : Q - 4'd1;
        end
    end

    assign seq_hit = (CHECK_SEQ != 0) && has_prev && (nxt_sh != succ);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            sh        <= 4'd0;
            dir_l     <= 1'b0;
            bcd_l     <= 1'b0;
            up_l      <= 1'b0;
            has_prev  <= 1'b0;
            Q         <= 4'd0;
            valid     <= 1'b0;
            range_err <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses regardless of En.
            valid     <= 1'b0;
            range_err <= 1'b0;
            seq_err   <= 1'b0;
            if (En) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= SHIFT;
                            cnt   <= 2'd1;
                            dir_l <= dir;
                            bcd_l <= bcd;
                            up_l  <= up;
                            sh    <= dir ? {sin, 3'b000} : {3'b000, sin};
                        end
                    end
                    SHIFT: begin
                        sh  <= nxt_sh;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state     <= IDLE;
                            cnt       <= 2'd0;
                            Q         <= nxt_sh;
                            valid     <= 1'b1;
                            range_err <= bcd_l && (nxt_sh > 4'd9);
                            seq_err   <= seq_hit;
                            has_prev  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nibble_deser.sv
// Directed bench for nibble_deser: a frame-level reference model checked every cycle,
// plus literal expectations on key frames.
module tb_nibble_deser;

    logic       clk = 1'b0;
    logic       rstn, En, start, sin, dir, bcd, up;
    logic [3:0] Q;
    logic       valid, range_err, seq_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int   model_q = 0;
    bit   model_has_prev = 1'b0;
    bit   exp_valid = 1'b0;
    bit   exp_rerr = 1'b0;
    bit   exp_serr = 1'b0;

    nibble_deser #(.CHECK_SEQ(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .En        (En),
        .start     (start),
        .sin       (sin),
        .dir       (dir),
        .bcd       (bcd),
        .up        (up),
        .Q         (Q),
        .valid     (valid),
        .range_err (range_err),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int succ(input int prev, input bit b, input bit u);
        if (b) begin
            if (prev > 9) return u ? 0 : 9;
            return u ? (prev + 1) % 10 : (prev + 9) % 10;
        end
        return u ? (prev + 1) % 16 : (prev + 15) % 16;
    endfunction

    always @(negedge clk) begin
        check("valid", {3'b0, valid}, {3'b0, exp_valid});
        check("range_err", {3'b0, range_err}, {3'b0, exp_rerr});
        check("seq_err", {3'b0, seq_err}, {3'b0, exp_serr});
        check("Q", Q, 4'(model_q));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_rerr  = 1'b0;
        exp_serr  = 1'b0;
    endtask

    // s0..s3 are the serial bits in transmission order. Mode inputs are inverted after
    // the start edge to show that only the values at frame start matter.
    task automatic frame(input bit s0, input bit s1, input bit s2, input bit s3,
                         input bit d, input bit b, input bit u,
                         input int stall_after, input int stall_n,
                         input bit mid_start, input int abort_after);
        bit s[4];
        int nib;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            En    = 1'b1;
            start = (i == 0) || (mid_start && i == 2);
            sin   = s[i];
            dir   = (i == 0) ? d : ~d;
            bcd   = (i == 0) ? b : ~b;
            up    = (i == 0) ? u : ~u;
            tick();
            if (i == abort_after) return;
            if (i == stall_after) begin
                En    = 1'b0;
                start = mid_start;
                sin   = ~sin;
                repeat (stall_n) tick();
            end
        end
        start = 1'b0;
        nib = d ? (s3 * 8 + s2 * 4 + s1 * 2 + s0) : (s0 * 8 + s1 * 4 + s2 * 2 + s3);
        exp_valid = 1'b1;
        exp_rerr  = b && (nib > 9);
        exp_serr  = model_has_prev && (nib != succ(model_q, b, u));
        model_has_prev = 1'b1;
        model_q = nib;
    endtask

    task automatic plain(input bit s0, input bit s1, input bit s2, input bit s3,
                         input bit d, input bit b, input bit u);
        frame(s0, s1, s2, s3, d, b, u, -1, 0, 1'b0, -1);
    endtask

    task automatic idle(input int n);
        En    = 1'b1;
        start = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rstn = 1'b1; En = 1'b0; start = 1'b0; sin = 1'b0; dir = 1'b0; bcd = 1'b0; up = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        check("reset_q", Q, 4'b0000);
        check("reset_valid", {3'b0, valid}, 4'd0);

        // MSB first, first frame after reset
        plain(1, 0, 1, 1, 0, 0, 1);
        check("msb_q", Q, 4'b1011);
        check("msb_seq", {3'b0, seq_err}, 4'd0);
        idle(2);

        // LSB first, same serial bits
        plain(1, 0, 1, 1, 1, 0, 1);
        check("lsb_q", Q, 4'b1101);
        idle(1);

        // BCD up, out-of-range nibble after 13: both errors
        plain(1, 1, 1, 0, 0, 1, 1);
        check("bcd_q", Q, 4'b1110);
        check("bcd_range", {3'b0, range_err}, 4'd1);
        check("bcd_seq", {3'b0, seq_err}, 4'd1);
        idle(1);

        // Back-to-back binary up 13,14,15,0
        plain(1, 1, 0, 1, 0, 0, 1);
        plain(1, 1, 1, 0, 0, 0, 1);
        plain(1, 1, 1, 1, 0, 0, 1);
        check("b2b_15_seq", {3'b0, seq_err}, 4'd0);
        plain(0, 0, 0, 0, 0, 0, 1);
        check("wrap_0_q", Q, 4'd0);
        check("wrap_0_seq", {3'b0, seq_err}, 4'd0);
        idle(2);

        // BCD down: 0 -> 9 is in sequence, 5 -> 3 is not
        plain(0, 0, 0, 0, 0, 1, 0);
        plain(1, 0, 0, 1, 0, 1, 0);
        check("bcd_dn_9_seq", {3'b0, seq_err}, 4'd0);
        check("bcd_dn_9_range", {3'b0, range_err}, 4'd0);
        plain(0, 1, 0, 1, 0, 1, 0);
        plain(0, 0, 1, 1, 0, 1, 0);
        check("bcd_dn_3_q", Q, 4'd3);
        check("bcd_dn_3_seq", {3'b0, seq_err}, 4'd1);
        idle(2);

        // En low for 3 cycles after bit 1, with a start pulse mid-frame
        frame(1, 0, 0, 1, 0, 0, 1, 1, 3, 1'b1, -1);
        check("stall_q", Q, 4'b1001);
        idle(2);

        // Reset after bit 2, then a clean frame
        frame(1, 1, 1, 1, 0, 0, 1, -1, 0, 1'b0, 2);
        rstn = 1'b0;
        model_q = 0;
        model_has_prev = 1'b0;
        tick();
        check("rst_mid_q", Q, 4'd0);
        tick();
        rstn = 1'b1;
        idle(1);
        plain(0, 1, 1, 0, 0, 0, 0);
        check("post_rst_q", Q, 4'b0110);
        check("post_rst_seq", {3'b0, seq_err}, 4'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
